// File: rtl/reg_hex_display_scan.sv
// Scans a frame-aligned snapshot of one 16-bit CPU register view as four hex
// digits onto a common-anode 7-segment display.
module reg_hex_display_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a0,
    input  logic [15:0] v0,
    input  logic [15:0] sp,
    input  logic [15:0] ra,
    input  logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic           DP_OFF   = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] pick_nibble(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] n;
        case (i)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            2'd3:    n = v[15:12];
            default: n = 4'h0;
        endcase
        return n;
    endfunction

    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       idx_r;
    logic [15:0]      shown_r;

    logic             tick_s;
    logic             load_s;
    logic [1:0]       idx_next_s;
    logic [15:0]      view_s;
    logic [15:0]      shown_next_s;
    logic [6:0]       seg_raw_s;
    logic [6:0]       seg_next_s;

    // Tick, snapshot and next-digit decode; digit 0 of a new frame uses the fresh snapshot.
    always_comb begin
        tick_s       = (div_cnt_r == DIV_LAST);
        load_s       = tick_s && (idx_r == 2'd3);
        idx_next_s   = idx_r;
        view_s       = a0;
        shown_next_s = shown_r;
        if (tick_s) begin
            idx_next_s = idx_r + 2'd1;
        end else begin
            idx_next_s = idx_r;
        end
        case (sel)
            2'b00:   view_s = a0;
            2'b01:   view_s = v0;
            2'b10:   view_s = sp;
            2'b11:   view_s = ra;
            default: view_s = a0;
        endcase
        if (load_s) begin
            shown_next_s = view_s;
        end else begin
            shown_next_s = shown_r;
        end
        seg_raw_s = hex_to_seg(pick_nibble(shown_next_s, idx_next_s));
        if (SEG_ACTIVE_LOW) begin
            seg_next_s = seg_raw_s;
        end else begin
            seg_next_s = ~seg_raw_s;
        end
    end

    // Prescaler, digit index, snapshot and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            idx_r      <= 2'd3;
            shown_r    <= 16'h0000;
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            if (tick_s) begin
                div_cnt_r <= {DIV_W{1'b0}};
                an        <= ~(4'b0001 << idx_next_s);
                seg       <= seg_next_s;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            idx_r      <= idx_next_s;
            shown_r    <= shown_next_s;
            dp         <= DP_OFF;
            frame_done <= load_s;
        end
    end

endmodule

// File: tb/tb_reg_hex_display_scan.sv
// Scoreboard bench: three instances (slow active-low, fast, active-high segments).
module tb_reg_hex_display_scan;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] a0, v0, sp, ra;
    logic [1:0]  sel_a, sel_b, sel_c;
    logic [3:0]  an_a, an_b, an_c;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dp_a, dp_b, dp_c;
    logic        fd_a, fd_b, fd_c;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    reg_hex_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .reset(reset), .a0(a0), .v0(v0), .sp(sp), .ra(ra), .sel(sel_a),
        .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a));
    reg_hex_display_scan #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset(reset), .a0(a0), .v0(v0), .sp(sp), .ra(ra), .sel(sel_b),
        .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b));
    reg_hex_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_c (
        .clk(clk), .reset(reset), .a0(a0), .v0(v0), .sp(sp), .ra(ra), .sel(sel_c),
        .an(an_c), .seg(seg_c), .dp(dp_c), .frame_done(fd_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    function automatic logic [3:0] nib_of(input logic [15:0] v, input int i);
        logic [15:0] t;
        t = v >> (4 * i);
        return t[3:0];
    endfunction

    function automatic void push_frame(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{an: ~(4'b0001 << i), seg: HEX[nib_of(v, i)], fd: (i == 0)});
        end
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        #2;
        checks++;
        if (an_a !== 4'b1111 || seg_a !== 7'h7F || dp_a !== 1'b1 || fd_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: an=%b seg=%h dp=%b fd=%b, want 1111 7f 1 0", an_a, seg_a, dp_a, fd_a);
        end
        checks++;
        if (an_b !== 4'b1111 || seg_b !== 7'h7F || fd_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: an=%b seg=%h fd=%b, want 1111 7f 0", an_b, seg_b, fd_b);
        end
        checks++;
        if (an_c !== 4'b1111 || seg_c !== 7'h00 || dp_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_c: an=%b seg=%h dp=%b, want 1111 00 0", an_c, seg_c, dp_c);
        end
    endtask

    task automatic test_scan;
        logic [3:0] hold_an;
        sel_a = 2'b00;
        a0 = 16'h1234;
        pulse_reset();
        push_frame(16'h1234);
        hold_an = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step(3);
            checks++;
            if (an_a !== hold_an || fd_a !== 1'b0) begin
                errors++;
                $display("FAIL scan_hold%0d: an=%b fd=%b, want %b 0", k, an_a, fd_a, hold_an);
            end
            step(1);
            e = sb.pop_front();
            checks++;
            if (an_a !== e.an || seg_a !== e.seg || fd_a !== e.fd || dp_a !== 1'b1) begin
                errors++;
                $display("FAIL scan_digit%0d: an=%b seg=%h fd=%b dp=%b, want %b %h %b 1",
                         k, an_a, seg_a, fd_a, dp_a, e.an, e.seg, e.fd);
            end
            hold_an = e.an;
        end
        push_frame(16'h1234);
        step(4);
        e = sb.pop_front();
        checks++;
        if (an_a !== e.an || seg_a !== e.seg || fd_a !== e.fd) begin
            errors++;
            $display("FAIL scan_frame2: an=%b seg=%h fd=%b, want %b %h %b", an_a, seg_a, fd_a, e.an, e.seg, e.fd);
        end
    endtask

    task automatic test_sel_change;
        step(4);
        e = sb.pop_front();
        checks++;
        if (an_a !== e.an || seg_a !== e.seg) begin
            errors++;
            $display("FAIL selchg_idx1: an=%b seg=%h, want %b %h", an_a, seg_a, e.an, e.seg);
        end
        sel_a = 2'b01;
        v0 = 16'hBEEF;
        push_frame(16'hBEEF);
        for (int k = 0; k < 6; k++) begin
            step(4);
            e = sb.pop_front();
            checks++;
            if (an_a !== e.an || seg_a !== e.seg || fd_a !== e.fd) begin
                errors++;
                $display("FAIL selchg_slot%0d: an=%b seg=%h fd=%b, want %b %h %b",
                         k, an_a, seg_a, fd_a, e.an, e.seg, e.fd);
            end
        end
    endtask

    task automatic test_mid_frame_input;
        exp_t cur;
        sel_a = 2'b00;
        a0 = 16'h9876;
        push_frame(16'h9876);
        step(4);
        cur = sb.pop_front();
        checks++;
        if (an_a !== cur.an || seg_a !== cur.seg || fd_a !== 1'b1) begin
            errors++;
            $display("FAIL midin_boundary: an=%b seg=%h fd=%b, want %b %h 1", an_a, seg_a, fd_a, cur.an, cur.seg);
        end
        for (int t = 1; t < 16; t++) begin
            a0 = 16'($urandom);
            step(1);
            if (t % 4 == 0) cur = sb.pop_front();
            checks++;
            if (an_a !== cur.an || seg_a !== cur.seg) begin
                errors++;
                $display("FAIL midin_edge%0d: an=%b seg=%h, want %b %h", t, an_a, seg_a, cur.an, cur.seg);
            end
        end
        a0 = 16'h4321;
    endtask

    task automatic test_reset_midframe;
        step(2);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (an_a !== 4'b1111 || seg_a !== 7'h7F || dp_a !== 1'b1 || fd_a !== 1'b0 ||
            an_b !== 4'b1111 || an_c !== 4'b1111 || seg_c !== 7'h00) begin
            errors++;
            $display("FAIL async_reset: a=%b/%h/%b/%b b=%b c=%b/%h, want 1111/7f/1/0 1111 1111/00",
                     an_a, seg_a, dp_a, fd_a, an_b, an_c, seg_c);
        end
        sel_a = 2'b00;
        a0 = 16'h4321;
        #1;
        reset = 1'b0;
        push_frame(16'h4321);
        step(3);
        checks++;
        if (an_a !== 4'b1111) begin
            errors++;
            $display("FAIL restart_dark: an=%b, want 1111", an_a);
        end
        step(1);
        e = sb.pop_front();
        checks++;
        if (an_a !== e.an || seg_a !== e.seg || fd_a !== e.fd) begin
            errors++;
            $display("FAIL restart_first: an=%b seg=%h fd=%b, want %b %h %b", an_a, seg_a, fd_a, e.an, e.seg, e.fd);
        end
        sb.delete();
    endtask

    task automatic test_fast;
        sel_b = 2'b10;
        sp = 16'hA5C0;
        pulse_reset();
        push_frame(16'hA5C0);
        push_frame(16'hA5C0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            e = sb.pop_front();
            checks++;
            if (an_b !== e.an || seg_b !== e.seg || fd_b !== e.fd || dp_b !== 1'b1) begin
                errors++;
                $display("FAIL fast_edge%0d: an=%b seg=%h fd=%b dp=%b, want %b %h %b 1",
                         k + 1, an_b, seg_b, fd_b, dp_b, e.an, e.seg, e.fd);
            end
        end
        sb.delete();
    endtask

    task automatic test_active_high;
        sel_c = 2'b11;
        ra = 16'h8888;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{an: ~(4'b0001 << i), seg: 7'h7F, fd: (i == 0)});
        end
        for (int k = 0; k < 4; k++) begin
            step(4);
            e = sb.pop_front();
            checks++;
            if (an_c !== e.an || seg_c !== e.seg || fd_c !== e.fd || dp_c !== 1'b0) begin
                errors++;
                $display("FAIL acthigh_slot%0d: an=%b seg=%h fd=%b dp=%b, want %b %h %b 0",
                         k, an_c, seg_c, fd_c, dp_c, e.an, e.seg, e.fd);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        a0 = 16'h0000;
        v0 = 16'h0000;
        sp = 16'h0000;
        ra = 16'h0000;
        sel_a = 2'b00;
        sel_b = 2'b00;
        sel_c = 2'b00;
        test_reset();
        test_scan();
        test_sel_change();
        test_mid_frame_input();
        test_reset_midframe();
        test_fast();
        test_active_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
